// File: rtl/a2d_pkg.sv
// a2d_pkg: shared types, widths and helpers for the scanning A2D interface.
//   ADC_W   - result width of the ADC128S-class converter
//   FRAME_W - SPI frame length in bits
//   MAX_CH  - largest supported number of logical channels
//   a2d_state_t  - scan FSM states
//   ch_map_entry - pull the 3-bit physical channel for a logical index
//   iir_step     - one update of the 4:1 averaging filter (used with A2D_AVG_EN)
package a2d_pkg;

    localparam int unsigned ADC_W   = 12;
    localparam int unsigned FRAME_W = 16;
    localparam int unsigned MAX_CH  = 8;

    typedef enum logic [2:0] {
        IDLE,
        TX1,
        GAP,
        TX2,
        DONE
    } a2d_state_t;

    function automatic logic [2:0] ch_map_entry(input logic [3*MAX_CH-1:0] map,
                                                input logic [2:0]          idx);
        logic [2:0] ent;
        ent = 3'd0;
        for (int k = 0; k < MAX_CH; k++) begin
            if (idx == 3'(k)) begin
                ent = map[3*k +: 3];
            end
        end
        return ent;
    endfunction

    // res + ((new - res) >>> 2) in signed 14-bit; the shift floors toward -inf.
    function automatic logic [ADC_W-1:0] iir_step(input logic [ADC_W-1:0] old_val,
                                                  input logic [ADC_W-1:0] new_val);
        logic signed [ADC_W+1:0] diff;
        logic signed [ADC_W+1:0] sum;
        diff = $signed({2'b00, new_val}) - $signed({2'b00, old_val});
        sum  = $signed({2'b00, old_val}) + (diff >>> 2);
        return sum[ADC_W-1:0];
    endfunction

endpackage

// File: rtl/a2d_spi_frame.sv
// a2d_spi_frame: one 16-bit SPI master frame to the ADC.
// The frame is 34 half-periods of SCLK_DIV/2 clks each: half 0 is setup, halves 1..32
// form 16 SCLK periods (odd half = SCLK low, even half = SCLK high), half 33 is hold.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   start         - pulse: begin a frame on the next edge (SS_n drops on that edge)
//   tx_word       - word shifted out MSB first, MOSI changes on SCLK fall
//   miso          - ADC data, sampled on SCLK rise
//   ss_n/sclk/mosi- registered SPI outputs (idle 1/1/0)
//   rx_data       - last 12 sampled bits (low 12 of the received frame)
//   frame_done    - high during the final SS_n-low clock of a frame
module a2d_spi_frame
    import a2d_pkg::*;
#(
    parameter int unsigned SCLK_DIV = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [FRAME_W-1:0] tx_word,
    input  logic               miso,
    output logic               ss_n,
    output logic               sclk,
    output logic               mosi,
    output logic [ADC_W-1:0]   rx_data,
    output logic               frame_done
);

    localparam int unsigned HALF     = SCLK_DIV / 2;
    localparam int unsigned HC_W     = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int unsigned LAST_HALF = 2 * FRAME_W + 1;

    logic               active;
    logic [HC_W-1:0]    hc;
    logic [5:0]         half;
    logic [5:0]         half_nxt;
    logic               half_end;
    logic [FRAME_W-1:0] tx_sh;
    logic [ADC_W-1:0]   rx_sh;

    assign half_end   = (hc == HC_W'(HALF - 1));
    assign half_nxt   = half + 6'd1;
    assign frame_done = active && half_end && (half == 6'(LAST_HALF));
    assign rx_data    = rx_sh;

    always_ff @(posedge clk) begin
        if (rst) begin
            active <= 1'b0;
            hc     <= '0;
            half   <= '0;
            tx_sh  <= '0;
            rx_sh  <= '0;
            ss_n   <= 1'b1;
            sclk   <= 1'b1;
            mosi   <= 1'b0;
        end else if (start) begin
            active <= 1'b1;
            hc     <= '0;
            half   <= '0;
            tx_sh  <= tx_word;
            ss_n   <= 1'b0;
            sclk   <= 1'b1;
            mosi   <= 1'b0;
        end else if (active) begin
            if (!half_end) begin
                hc <= hc + 1'b1;
            end else begin
                hc <= '0;
                if (frame_done) begin
                    active <= 1'b0;
                    ss_n   <= 1'b1;
                    mosi   <= 1'b0;
                end else begin
                    half <= half_nxt;
                    if (half_nxt == 6'(LAST_HALF)) begin
                        // entering hold: SCLK already high, nothing changes
                    end else if (half_nxt[0]) begin
                        sclk  <= 1'b0;
                        mosi  <= tx_sh[FRAME_W-1];
                        tx_sh <= {tx_sh[FRAME_W-2:0], 1'b0};
                    end else begin
                        sclk  <= 1'b1;
                        rx_sh <= {rx_sh[ADC_W-2:0], miso};
                    end
                end
            end
        end
    end

endmodule

// File: rtl/a2d_scan_intf.sv
// a2d_scan_intf: scanning SPI interface to an ADC128S-class 8-channel 12-bit converter.
// Each conversion runs two frames: TX1 addresses the channel (its data is discarded),
// a 2-clk SS_n-high gap, then TX2 returns the conversion, stored in res slot idx.
// Optional build macro A2D_AVG_EN turns each slot into a 4:1 IIR filter; the first
// sample after reset loads raw.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   nxt        - pulse: convert the next logical channel (ignored while busy)
//   auto_en    - continuous round-robin scan
//   MISO       - ADC serial data
//   SS_n, SCLK, MOSI - SPI master outputs
//   busy       - conversion in progress (through DONE)
//   cnv_cmplt  - one-cycle pulse when a result has been written
//   cnv_ch     - logical index of the last completed channel
//   res        - packed results, logical i at [12i+11:12i]
module a2d_scan_intf
    import a2d_pkg::*;
#(
    parameter int unsigned NUM_CH   = 3,
    parameter int unsigned SCLK_DIV = 32,
    parameter logic [23:0] CH_MAP   = 24'h000160
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    nxt,
    input  logic                    auto_en,
    input  logic                    MISO,
    output logic                    SS_n,
    output logic                    SCLK,
    output logic                    MOSI,
    output logic                    busy,
    output logic                    cnv_cmplt,
    output logic [2:0]              cnv_ch,
    output logic [NUM_CH*ADC_W-1:0] res
);

    localparam logic [2:0] LAST_IDX = 3'(NUM_CH - 1);

    a2d_state_t         state;
    logic [2:0]         idx;
    logic               gap_cnt;
    logic               start_tx;
    logic               frame_done;
    logic               wr_en;
    logic [ADC_W-1:0]   rx_data;
    logic [FRAME_W-1:0] tx_word;
    logic [ADC_W-1:0]   slot [NUM_CH];

    assign tx_word  = {2'b00, ch_map_entry(CH_MAP, idx), 11'h000};
    // GAP holds for two clks; the second one launches TX2 so SS_n is high exactly 2 clks.
    assign start_tx = ((state == IDLE) && (nxt || auto_en)) || ((state == GAP) && gap_cnt);
    assign wr_en    = (state == TX2) && frame_done;

    a2d_spi_frame #(
        .SCLK_DIV (SCLK_DIV)
    ) u_frame (
        .clk        (clk),
        .rst        (rst),
        .start      (start_tx),
        .tx_word    (tx_word),
        .miso       (MISO),
        .ss_n       (SS_n),
        .sclk       (SCLK),
        .mosi       (MOSI),
        .rx_data    (rx_data),
        .frame_done (frame_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= 3'd0;
            gap_cnt   <= 1'b0;
            busy      <= 1'b0;
            cnv_cmplt <= 1'b0;
            cnv_ch    <= 3'd0;
        end else begin
            cnv_cmplt <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (nxt || auto_en) begin
                        state <= TX1;
                        busy  <= 1'b1;
                    end
                end
                TX1: begin
                    if (frame_done) begin
                        state   <= GAP;
                        gap_cnt <= 1'b0;
                    end
                end
                GAP: begin
                    if (gap_cnt) begin
                        state <= TX2;
                    end else begin
                        gap_cnt <= 1'b1;
                    end
                end
                TX2: begin
                    if (frame_done) begin
                        state     <= DONE;
                        cnv_cmplt <= 1'b1;
                        cnv_ch    <= idx;
                        idx       <= (idx == LAST_IDX) ? 3'd0 : idx + 3'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef A2D_AVG_EN
    logic [NUM_CH-1:0] primed;

    always_ff @(posedge clk) begin
        if (rst) begin
            primed <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                slot[k] <= '0;
            end
        end else if (wr_en) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (idx == 3'(k)) begin
                    slot[k]   <= primed[k] ? iir_step(slot[k], rx_data) : rx_data;
                    primed[k] <= 1'b1;
                end
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_CH; k++) begin
                slot[k] <= '0;
            end
        end else if (wr_en) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (idx == 3'(k)) begin
                    slot[k] <= rx_data;
                end
            end
        end
    end
`endif

    for (genvar g = 0; g < NUM_CH; g++) begin : g_res
        assign res[g*ADC_W +: ADC_W] = slot[g];
    end

endmodule

// File: tb/tb_a2d_scan_intf.sv
// tb_a2d_scan_intf: directed bench with an ADC128S behavioural model and a scoreboard
// of expected conversions, checked on every cnv_cmplt.
module tb_a2d_scan_intf;

    localparam int unsigned D   = 32;
    localparam int unsigned LAT = 34 * D + 3;

    logic clk = 1'b0;
    logic rst, nxt, auto_en, miso;
    logic ss_n, sclk, mosi, busy, cnv_cmplt;
    logic [2:0]  cnv_ch;
    logic [35:0] res;

    a2d_scan_intf #(
        .NUM_CH   (3),
        .SCLK_DIV (D),
        .CH_MAP   (24'h000160)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .nxt       (nxt),
        .auto_en   (auto_en),
        .MISO      (miso),
        .SS_n      (ss_n),
        .SCLK      (sclk),
        .MOSI      (mosi),
        .busy      (busy),
        .cnv_cmplt (cnv_cmplt),
        .cnv_ch    (cnv_ch),
        .res       (res)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  ch;
        logic [11:0] raw;
        logic [2:0]  addr;
        int          start;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          last_cmplt = 0;
    int          exp_idx = 0;
    logic [11:0] adc_val [8];
    logic [11:0] model [3];
    logic        primed [3];
    logic [2:0]  phys [3] = '{3'd0, 3'd4, 3'd5};

    // ADC model state
    logic [15:0] out_word = 16'h0;
    logic [15:0] cap = 16'h0;
    logic [15:0] last_word = 16'h0;
    logic [15:0] prev_word = 16'h0;
    logic [2:0]  adc_addr = 3'd0;
    int          bitk = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [11:0] iir(input logic [11:0] o, input logic [11:0] n);
        int d, q;
        d = int'(n) - int'(o);
        q = (d >= 0) ? d / 4 : -((-d + 3) / 4);
        return 12'(int'(o) + q);
    endfunction

    // ADC: conversion data is for the address received in the previous frame,
    // four leading zeros then 12 bits MSB first, each bit driven on an SCLK fall.
    always @(negedge ss_n) begin
        bitk     = 0;
        out_word = {4'h0, adc_val[adc_addr]};
    end
    always @(negedge sclk) begin
        if (ss_n === 1'b0 && bitk < 16) begin
            miso = out_word[15 - bitk];
            bitk++;
        end
    end
    always @(posedge sclk) begin
        if (ss_n === 1'b0) cap = {cap[14:0], mosi};
    end
    always @(posedge ss_n) begin
        prev_word = last_word;
        last_word = cap;
        adc_addr  = cap[13:11];
        cap       = 16'h0;
    end

    always @(negedge clk) begin
        if (cnv_cmplt === 1'b1) begin
            check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
`ifdef A2D_AVG_EN
                model[e.ch]  = primed[e.ch] ? iir(model[e.ch], e.raw) : e.raw;
                primed[e.ch] = 1'b1;
`else
                model[e.ch] = e.raw;
`endif
                check("cnv_ch", 64'(cnv_ch), 64'(e.ch));
                check("res", 64'(res), 64'({model[2], model[1], model[0]}));
                check("tx1_word", 64'(prev_word), 64'({2'b00, e.addr, 11'h000}));
                check("tx2_word", 64'(last_word), 64'({2'b00, e.addr, 11'h000}));
                check("busy_done", 64'(busy), 64'd1);
                if (e.start >= 0) check("latency", 64'(cyc - e.start), 64'(LAT));
                else check("interval", 64'(cyc - last_cmplt), 64'(LAT + 1));
            end
            last_cmplt = cyc;
        end
    end

    task automatic push_exp(input int start);
        exp_t x;
        x.ch    = 3'(exp_idx);
        x.addr  = phys[exp_idx];
        x.raw   = adc_val[phys[exp_idx]];
        x.start = start;
        sb.push_back(x);
        exp_idx = (exp_idx + 1) % 3;
    endtask

    task automatic pulse_nxt();
        @(negedge clk);
        nxt = 1'b1;
        push_exp(cyc);
        @(negedge clk);
        nxt = 1'b0;
    endtask

    task automatic wait_size(input int n);
        int budget;
        budget = 20000;
        while (sb.size() > n && budget > 0) begin
            @(negedge clk);
            #1;
            budget--;
        end
        check("wait_timeout", 64'(budget == 0), 64'd0);
    endtask

    initial begin
        rst = 1'b1; nxt = 1'b0; auto_en = 1'b0; miso = 1'b0;
        adc_val = '{12'h400, 12'h111, 12'h222, 12'h333, 12'h3FD, 12'hFFE, 12'h666, 12'h777};
        for (int i = 0; i < 3; i++) begin model[i] = 12'h0; primed[i] = 1'b0; end
        repeat (3) @(negedge clk);
        check("rst_ss_n", 64'(ss_n), 64'd1);
        check("rst_sclk", 64'(sclk), 64'd1);
        check("rst_mosi", 64'(mosi), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_cmplt", 64'(cnv_cmplt), 64'd0);
        check("rst_cnv_ch", 64'(cnv_ch), 64'd0);
        check("rst_res", 64'(res), 64'd0);
        rst = 1'b0;

        // single manual conversion of slot 0
        pulse_nxt();
        repeat (10) @(negedge clk);
        check("busy_mid", 64'(busy), 64'd1);
        wait_size(0);
        check("slot0_first", 64'(res[11:0]), 64'h400);

        // slots 1, 2 then wrap to slot 0 with new data
        adc_val[0] = 12'h123;
        repeat (3) begin
            pulse_nxt();
            wait_size(0);
        end
        check("slot1", 64'(res[23:12]), 64'h3FD);
        check("slot2", 64'(res[35:24]), 64'hFFE);
        check("slot0_wrap", 64'(res[11:0]), 64'h123);

        // nxt during TX2 is dropped
        pulse_nxt();
        repeat (700) @(negedge clk);
        check("busy_tx2", 64'(busy), 64'd1);
        check("ss_n_tx2", 64'(ss_n), 64'd0);
        nxt = 1'b1;
        @(negedge clk);
        nxt = 1'b0;
        wait_size(0);
        repeat (2) @(negedge clk);
        check("busy_after", 64'(busy), 64'd0);
        repeat (1200) @(negedge clk);
        check("idle_ss_n", 64'(ss_n), 64'd1);

        // auto scan: 10 conversions, drop auto_en during TX1 of the 10th
        @(negedge clk);
        auto_en = 1'b1;
        for (int i = 0; i < 10; i++) push_exp((i == 0) ? cyc : -1);
        wait_size(1);
        repeat (100) @(negedge clk);
        check("auto_in_tx1", 64'(ss_n), 64'd0);
        auto_en = 1'b0;
        wait_size(0);
        repeat (1200) @(negedge clk);
        check("auto_stop_busy", 64'(busy), 64'd0);
        check("auto_stop_ss_n", 64'(ss_n), 64'd1);

        // reset while SCLK is low inside TX1
        begin
            int budget;
            budget = 2000;
            pulse_nxt();
            while (!(sclk === 1'b0 && ss_n === 1'b0) && budget > 0) begin
                @(negedge clk);
                budget--;
            end
            check("sclk_low_seen", 64'(budget == 0), 64'd0);
        end
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_ss_n", 64'(ss_n), 64'd1);
        check("mid_rst_sclk", 64'(sclk), 64'd1);
        check("mid_rst_mosi", 64'(mosi), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_res", 64'(res), 64'd0);
        sb.delete();
        for (int i = 0; i < 3; i++) begin model[i] = 12'h0; primed[i] = 1'b0; end
        exp_idx = 0;
        rst = 1'b0;

        // slot 0 sees 0x400, 0x800, 0x000 across three rounds
        adc_val[0] = 12'h400;
        pulse_nxt();
        wait_size(0);
        check("seq0_a", 64'(res[11:0]), 64'h400);
        check("seq0_a_ch", 64'(cnv_ch), 64'd0);
        pulse_nxt(); wait_size(0);
        pulse_nxt(); wait_size(0);
        adc_val[0] = 12'h800;
        pulse_nxt();
        wait_size(0);
`ifdef A2D_AVG_EN
        check("seq0_b", 64'(res[11:0]), 64'h500);
`else
        check("seq0_b", 64'(res[11:0]), 64'h800);
`endif
        pulse_nxt(); wait_size(0);
        pulse_nxt(); wait_size(0);
        adc_val[0] = 12'h000;
        pulse_nxt();
        wait_size(0);
`ifdef A2D_AVG_EN
        check("seq0_c", 64'(res[11:0]), 64'h3C0);
`else
        check("seq0_c", 64'(res[11:0]), 64'h000);
`endif
        repeat (5) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
